// File: rtl/audio_i2s_out.sv
// Stereo I2S transmitter: converts unsigned 11-bit mixer levels to signed 16-bit PCM.
// Optional first-order sigma-delta outputs are built only when AUDIO_SDM_EN is defined.
module audio_i2s_out #(
  parameter int BCLK_DIV = 4
) (
  input  logic        ppu_vm_clk_p,
  input  logic        ppu_vm_init_i,
  input  logic [10:0] l_channel_i,
  input  logic [10:0] r_channel_i,
  input  logic        mute_i,
  output logic        sample_stb_o,
  output logic        i2s_bclk_o,
  output logic        i2s_lrck_o,
  output logic        i2s_dat_o,
  output logic        sdm_l_o,
  output logic        sdm_r_o
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DW-1:0] d_reg;
  logic          bclk_reg;
  logic [4:0]    b_reg;
  logic [31:0]   shift_reg;
  logic [15:0]   cap_l_reg;
  logic [15:0]   cap_r_reg;
  logic          stb_reg;
  logic          tick;
  logic          fall;

  // Offset-binary to two's complement: mid-scale 1024 maps to zero.
  function automatic logic [15:0] conv(input logic [10:0] x, input logic m);
    return m ? 16'h0000 : ({1'b0, x, 4'b0000} - 16'h4000);
  endfunction

  assign tick = (d_reg == DW'(BCLK_DIV - 1));
  assign fall = tick & bclk_reg;

  always_ff @(posedge ppu_vm_clk_p) begin
    if (ppu_vm_init_i) begin
      d_reg     <= '0;
      bclk_reg  <= 1'b0;
      b_reg     <= '0;
      shift_reg <= '0;
      cap_l_reg <= '0;
      cap_r_reg <= '0;
      stb_reg   <= 1'b0;
    end else begin
      stb_reg <= 1'b0;
      if (tick) begin
        d_reg    <= '0;
        bclk_reg <= ~bclk_reg;
      end else begin
        d_reg <= d_reg + DW'(1);
      end
      if (fall) begin
        b_reg <= b_reg + 5'd1;
        if (b_reg == 5'd31) begin
          // Entering slot 0: latch the next frame; R[0] of this frame still shifts out.
          cap_l_reg <= conv(l_channel_i, mute_i);
          cap_r_reg <= conv(r_channel_i, mute_i);
          stb_reg   <= 1'b1;
          shift_reg <= shift_reg << 1;
        end else if (b_reg == 5'd0) begin
          shift_reg <= {cap_l_reg, cap_r_reg};
        end else begin
          shift_reg <= shift_reg << 1;
        end
      end
    end
  end

  assign sample_stb_o = stb_reg;
  assign i2s_bclk_o   = bclk_reg;
  assign i2s_lrck_o   = b_reg[4];
  assign i2s_dat_o    = shift_reg[31];

`ifdef AUDIO_SDM_EN
  logic [10:0] sdm_in [2];
  logic [1:0]  sdm_bit;

  assign sdm_in[0] = mute_i ? 11'd0 : l_channel_i;
  assign sdm_in[1] = mute_i ? 11'd0 : r_channel_i;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sdm
      logic [10:0] acc_reg;
      logic        out_reg;
      logic [11:0] sum;

      assign sum = {1'b0, acc_reg} + {1'b0, sdm_in[gi]};

      always_ff @(posedge ppu_vm_clk_p) begin
        if (ppu_vm_init_i) begin
          acc_reg <= '0;
          out_reg <= 1'b0;
        end else begin
          acc_reg <= sum[10:0];
          out_reg <= sum[11];
        end
      end

      assign sdm_bit[gi] = out_reg;
    end
  endgenerate

  assign sdm_l_o = sdm_bit[0];
  assign sdm_r_o = sdm_bit[1];
`else
  assign sdm_l_o = 1'b0;
  assign sdm_r_o = 1'b0;
`endif

endmodule

// File: tb/tb_audio_i2s_out.sv
// Self-checking bench for audio_i2s_out: decodes the I2S stream on BCLK rising edges
// and compares against PCM words computed from the input levels present at capture.
module tb_audio_i2s_out;

  localparam int DIV = 2;
  localparam int FRAME = 64 * DIV;

  logic        clk = 1'b0;
  logic        srst;
  logic [10:0] l_in;
  logic [10:0] r_in;
  logic        mute;
  logic        stb;
  logic        bclk;
  logic        lrck;
  logic        dat;
  logic        sdm_l;
  logic        sdm_r;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  audio_i2s_out #(.BCLK_DIV(DIV)) dut (
    .ppu_vm_clk_p (clk),
    .ppu_vm_init_i(srst),
    .l_channel_i  (l_in),
    .r_channel_i  (r_in),
    .mute_i       (mute),
    .sample_stb_o (stb),
    .i2s_bclk_o   (bclk),
    .i2s_lrck_o   (lrck),
    .i2s_dat_o    (dat),
    .sdm_l_o      (sdm_l),
    .sdm_r_o      (sdm_r)
  );

  // Reference PCM value: level scaled by 16, minus half-scale, taken modulo 2^16.
  function automatic logic [15:0] model_pcm(input int x, input bit m);
    int v;
    if (m) return 16'h0000;
    v = x * 16 - 16384;
    if (v < 0) v += 65536;
    return v[15:0];
  endfunction

  task automatic wait_stb(output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < FRAME + 8; i++) begin
      @(negedge clk);
      if (stb) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  // Called right after a strobe; gathers the 32 bits of the just-captured frame.
  task automatic collect_frame(output logic [31:0] word, output int lrck_bad,
                               output int period, output bit timeout);
    int   edges = 0;
    int   cnt = 0;
    int   slot;
    logic prev = bclk;
    word = '0; lrck_bad = 0; period = 0; timeout = 1'b1;
    while (cnt < 2 * FRAME) begin
      @(negedge clk);
      cnt++;
      if (stb && period == 0) period = cnt;
      if (bclk && !prev) begin
        edges++;
        if (edges >= 2) begin
          slot = (edges - 1) % 32;
          word = {word[30:0], dat};
          if (lrck !== (slot >= 16)) lrck_bad++;
        end
        if (edges == 33) begin
          timeout = 1'b0;
          prev = bclk;
          break;
        end
      end
      prev = bclk;
    end
  endtask

  task automatic test_reset;
    int n = 0;
    int ones = 0;
    int first_rise = -1;
    int last_tog = 0;
    int bad_half = 0;
    logic prev;
    srst = 1'b1; l_in = '0; r_in = '0; mute = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({stb, bclk, lrck, dat, sdm_l, sdm_r} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=000000", {stb, bclk, lrck, dat, sdm_l, sdm_r});
    end
    srst = 1'b0;
    prev = bclk;
    while (n < FRAME + 8) begin
      @(negedge clk);
      n++;
      if (dat) ones++;
      if (bclk !== prev) begin
        if (first_rise < 0) first_rise = n;
        else if (n - last_tog != DIV) bad_half++;
        last_tog = n;
      end
      prev = bclk;
      if (stb) break;
    end
    checks++;
    if (n != FRAME || stb !== 1'b1) begin
      failures++;
      $display("FAIL first_strobe got=%0d cycles want=%0d", n, FRAME);
    end
    checks++;
    if (first_rise != DIV) begin
      failures++;
      $display("FAIL first_bclk_rise got=%0d want=%0d", first_rise, DIV);
    end
    checks++;
    if (bad_half != 0) begin
      failures++;
      $display("FAIL bclk_half_period bad=%0d want=0", bad_half);
    end
    checks++;
    if (ones != 0) begin
      failures++;
      $display("FAIL first_frame_zero ones=%0d want=0", ones);
    end
    $display("reset: strobe after %0d cycles, first bclk toggle at %0d", n, first_rise);
  endtask

  // One frame with fixed levels; mute and levels scrambled once captured.
  task automatic run_frame(input string name, input int l, input int r, input bit m);
    bit          to;
    logic [31:0] word;
    logic [31:0] want;
    int          lb;
    int          per;
    l_in = 11'(l); r_in = 11'(r); mute = m;
    wait_stb(to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL %s_strobe_timeout", name);
      return;
    end
    want = {model_pcm(l, m), model_pcm(r, m)};
    l_in = 11'($urandom_range(0, 2047));
    r_in = 11'($urandom_range(0, 2047));
    mute = ~m;
    collect_frame(word, lb, per, to);
    checks++;
    if (to || word !== want) begin
      failures++;
      $display("FAIL %s_word got=%h want=%h timeout=%0d", name, word, want, to);
    end
    checks++;
    if (lb != 0) begin
      failures++;
      $display("FAIL %s_lrck bad_slots=%0d want=0", name, lb);
    end
    checks++;
    if (per != FRAME) begin
      failures++;
      $display("FAIL %s_strobe_period got=%0d want=%0d", name, per, FRAME);
    end
    $display("%s: l=%0d r=%0d mute=%0d word=%h want=%h", name, l, r, m, word, want);
  endtask

  task automatic test_frame_content;
    run_frame("frame_1024_0", 1024, 0, 1'b0);
  endtask

  task automatic test_full_scale;
    run_frame("full_scale", 2047, 2047, 1'b0);
    run_frame("zero_scale", 0, 0, 1'b0);
  endtask

  task automatic test_mute;
    run_frame("mute_zero", 0, 0, 1'b1);
    run_frame("mute_rand", $urandom_range(1, 2047), $urandom_range(1, 2047), 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++)
      run_frame("random", $urandom_range(0, 2047), $urandom_range(0, 2047), ($urandom_range(0, 3) == 0));
  endtask

  task automatic test_reset_mid_frame;
    bit to;
    int n = 0;
    wait_stb(to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL midreset_strobe_timeout");
      return;
    end
    repeat (20 * 2 * DIV) @(negedge clk);
    checks++;
    if (lrck !== 1'b1) begin
      failures++;
      $display("FAIL midreset_slot20_lrck got=%b want=1", lrck);
    end
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    checks++;
    if ({stb, bclk, lrck, dat} !== 4'b0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b want=0000", {stb, bclk, lrck, dat});
    end
    while (n < FRAME + 8) begin
      @(negedge clk);
      n++;
      if (stb) break;
    end
    checks++;
    if (n != FRAME || stb !== 1'b1) begin
      failures++;
      $display("FAIL midreset_restart got=%0d cycles want=%0d", n, FRAME);
    end
    $display("reset_mid_frame: strobe %0d cycles after release", n);
  endtask

  task automatic test_sdm;
    int ones_l = 0;
    int ones_r = 0;
    int want_l;
    int want_r;
    l_in = 11'd1024; r_in = 11'd512; mute = 1'b0;
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      if (sdm_l) ones_l++;
      if (sdm_r) ones_r++;
    end
`ifdef AUDIO_SDM_EN
    want_l = 2048; want_r = 1024;
`else
    want_l = 0; want_r = 0;
`endif
    checks++;
    if (ones_l != want_l) begin
      failures++;
      $display("FAIL sdm_left_ones got=%0d want=%0d", ones_l, want_l);
    end
    checks++;
    if (ones_r != want_r) begin
      failures++;
      $display("FAIL sdm_right_ones got=%0d want=%0d", ones_r, want_r);
    end
    $display("sdm: ones_l=%0d ones_r=%0d", ones_l, ones_r);
  endtask

  initial begin
    srst = 1'b1; l_in = '0; r_in = '0; mute = 1'b0;
    test_reset();
    test_frame_content();
    test_full_scale();
    test_mute();
    test_random();
    test_reset_mid_frame();
    test_sdm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
